// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants, types and helpers for the FIFO read-side drain
package fifo_pkg;
    localparam int BUF_DEPTH = 2;
    typedef logic [1:0] buf_cnt_t;
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] mx;
        mx = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (v == mx) ? v : v + 32'd1;
    endfunction
endpackage

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid: 2-entry in-order output buffer; e0 is always the head
module fifo_rd_skid
    import fifo_pkg::*;
#(
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DWIDTH-1:0] push_data,
    input  logic              pop,
    output logic [DWIDTH-1:0] head,
    output logic              valid,
    output buf_cnt_t          count
);
    logic [DWIDTH-1:0] e0, e1;
    // shift on pop; a push lands in the first free slot after any pop
    always_ff @(posedge clk) begin
        if (rst) begin
            e0    <= '0;
            e1    <= '0;
            count <= '0;
        end else begin
            count <= count + buf_cnt_t'(push) - buf_cnt_t'(pop);
            if (pop) e0 <= (push && count == 2'd1) ? push_data : e1;
            else if (push && count == 2'd0) e0 <= push_data;
            if (push && (pop ? count == 2'd2 : count == 2'd1)) e1 <= push_data;
        end
    end
    // credit logic upstream must never push into a full buffer without a pop
    always_ff @(posedge clk) begin
        if (!rst) assert (!(push && !pop && count == 2'd2));
    end
    assign head  = e0;
    assign valid = count != 2'd0;
endmodule

// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain: pops the async FIFO read side into a valid/ready stream at full rate
// Optional statistics counters are enabled with FIFO_RD_STATS_EN.
module fifo_rd_drain
    import fifo_pkg::*;
#(
    parameter int DWIDTH = 8
`ifdef FIFO_RD_STATS_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              rclk,
    input  logic              rrst,
    input  logic              empty,
    input  logic [DWIDTH-1:0] rdata,
    output logic              renable,
    output logic              m_valid,
    output logic [DWIDTH-1:0] m_data,
    input  logic              m_ready
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [CNT_W-1:0]  pop_count,
    output logic [CNT_W-1:0]  starve_count
`endif
);
    logic     inflight, pop;
    buf_cnt_t buf_cnt;
    logic [2:0] credit;
    // pop only while occupancy after this cycle leaves room for the returning word
    always_comb begin
        pop     = m_valid && m_ready;
        credit  = 3'(buf_cnt) + 3'(inflight) - 3'(pop);
        renable = !rrst && !empty && credit < 3'(BUF_DEPTH);
    end
    // one-cycle FIFO read latency: the word requested now arrives next cycle
    always_ff @(posedge rclk) begin
        inflight <= rrst ? 1'b0 : renable;
    end
    fifo_rd_skid #(.DWIDTH(DWIDTH)) u_skid (
        .clk       (rclk),
        .rst       (rrst),
        .push      (inflight),
        .push_data (rdata),
        .pop       (pop),
        .head      (m_data),
        .valid     (m_valid),
        .count     (buf_cnt)
    );
`ifdef FIFO_RD_STATS_EN
    // saturating pop and starvation counters
    always_ff @(posedge rclk) begin
        if (rrst) begin
            pop_count    <= '0;
            starve_count <= '0;
        end else begin
            if (renable) pop_count <= CNT_W'(sat_inc(32'(pop_count), CNT_W));
            if (m_ready && !m_valid) starve_count <= CNT_W'(sat_inc(32'(starve_count), CNT_W));
        end
    end
`endif
endmodule

// File: tb/tb_fifo_rd_drain.sv
// tb_fifo_rd_drain: scoreboard bench for fifo_rd_drain with a behavioural FIFO read side
module tb_fifo_rd_drain;
    logic       rclk = 1'b0;
    logic       rrst = 1'b1;
    logic       empty = 1'b1;
    logic       m_ready = 1'b0;
    logic [7:0] rdata = 8'h00;
    logic       renable, m_valid;
    logic [7:0] m_data;
`ifdef FIFO_RD_STATS_EN
    logic [3:0] pop_count, starve_count;
`endif
    int         errors = 0;
    int         checks = 0;
    logic [7:0] fq[$];
    logic [7:0] exp_q[$];
    logic       gate = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always #5 rclk = ~rclk;

    fifo_rd_drain #(
        .DWIDTH(8)
`ifdef FIFO_RD_STATS_EN
        ,
        .CNT_W(4)
`endif
    ) dut (
        .rclk    (rclk),
        .rrst    (rrst),
        .empty   (empty),
        .rdata   (rdata),
        .renable (renable),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_ready (m_ready)
`ifdef FIFO_RD_STATS_EN
        ,
        .pop_count    (pop_count),
        .starve_count (starve_count)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge rclk);
        #1;
    endtask

    task automatic push(input logic [7:0] w);
        fq.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || m_valid) && k < budget) begin
            tick(1);
            k++;
        end
        check("drain_done", exp_q.size(), 0);
    endtask

    // FIFO read-side model: a pop requested in one cycle presents its word the next cycle
    initial begin
        logic pend;
        forever begin
            @(negedge rclk);
            pend = renable && !empty;
            @(posedge rclk);
            #2;
            if (pend && fq.size() != 0) rdata = fq.pop_front();
            empty = gate || fq.size() == 0;
        end
    end

    // monitor: scoreboard compare on every transfer, plus stream and FIFO protocol checks
    initial begin
        forever begin
            @(negedge rclk);
            if (renable) check("renable_while_empty", empty, 0);
            if (!rrst && prev_stall) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, prev_data);
            end
            if (!rrst && m_valid && m_ready) begin
                if (exp_q.size() == 0) check("unexpected_word", m_data, 32'hffff_ffff);
                else check("m_data", m_data, exp_q.pop_front());
            end
            prev_stall = !rrst && m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ren_cnt, ren_first, ren_last, dl_cnt, dl_first, dl_last, k;
        // reset held with data available and downstream ready
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push(8'(i));
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("rst_renable", renable, 0);
            check("rst_m_valid", m_valid, 0);
            check("rst_m_data", m_data, 0);
        end
        // full-rate drain of 8 preloaded words
        rrst = 1'b0;
        ren_cnt = 0; ren_first = -1; ren_last = -1;
        dl_cnt = 0; dl_first = -1; dl_last = -1;
        for (int i = 0; i < 20; i++) begin
            #2;
            if (renable) begin
                ren_cnt++;
                if (ren_first < 0) ren_first = i;
                ren_last = i;
            end
            if (m_valid && m_ready) begin
                dl_cnt++;
                if (dl_first < 0) dl_first = i;
                dl_last = i;
            end
            tick(1);
        end
        check("t2_ren_count", ren_cnt, 8);
        check("t2_ren_contig", ren_last - ren_first, 7);
        check("t2_out_count", dl_cnt, 8);
        check("t2_out_contig", dl_last - dl_first, 7);
        check("t2_latency", dl_first - ren_first, 2);
        check("t2_drained", exp_q.size(), 0);
        // back-pressure: only two words may be pulled out of the FIFO
        m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(8'(i));
        ren_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            #2;
            if (renable) ren_cnt++;
            tick(1);
        end
        check("t3_ren_pulses", ren_cnt, 2);
        check("t3_valid", m_valid, 1);
        check("t3_data", m_data, 8'h01);
        m_ready = 1'b1;
        drain(60);
        // empty toggling with random back-pressure
        k = 0;
        for (int i = 0; i < 40; i++) begin
            gate = ~gate;
            m_ready = 1'($urandom_range(0, 1));
            if (i % 2 == 0 && k < 6) begin
                push(8'h21 + 8'(k));
                k++;
            end
            tick(1);
        end
        gate = 1'b0;
        m_ready = 1'b1;
        drain(60);
        // reset with one buffered and one in-flight word
        m_ready = 1'b0;
        push(8'h30); push(8'h31); push(8'h32);
        k = 0;
        while (!m_valid && k < 10) begin
            tick(1);
            k++;
        end
        check("t5_reached_valid", m_valid, 1);
        rrst = 1'b1;
        fq.delete();
        exp_q.delete();
        tick(1);
        check("t5_valid_cleared", m_valid, 0);
        check("t5_data_cleared", m_data, 0);
        rrst = 1'b0;
        m_ready = 1'b1;
        push(8'h40); push(8'h41);
        drain(30);
`ifdef FIFO_RD_STATS_EN
        // statistics: starvation count, then pop count up to saturation
        m_ready = 1'b0;
        rrst = 1'b1;
        tick(2);
        rrst = 1'b0;
        tick(1);
        m_ready = 1'b1;
        tick(3);
        m_ready = 1'b0;
        tick(1);
        check("t6_starve", starve_count, 3);
        check("t6_pop_zero", pop_count, 0);
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) push(8'h50 + 8'(i));
        drain(40);
        check("t6_pop5", pop_count, 5);
        for (int i = 0; i < 20; i++) push(8'h60 + 8'(i));
        drain(100);
        check("t6_pop_sat", pop_count, 15);
`endif
        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
